data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised data memory for the pipelined CPU's MEM stage, replacing the fixed 256-word, word-only data RAM. Adds byte/halfword/word access with sign or zero extension, alignment and range checking, and a valid/ready request port with a registered one-cycle response. A post-reset init sequencer clears or preloads the array one word per cycle, so the array maps onto block RAM. A registered peek output exposes one configurable word for the board display.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two ≥ 4; index width IW = $clog2(DEPTH)
- PEEK_IDX, 4, word index mirrored on peek_data; must be < DEPTH

Ports:
- clk  in  1  single clock; everything updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_wr  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  request rejected (misaligned, out of range or illegal size)
- init_done  out  1  init sequence complete
- peek_data  out  32  registered copy of word PEEK_IDX

## Operation
- FSM states: INIT, IDLE. Reset assertion forces INIT with init index 0.
- INIT:
  - Each cycle writes the init value to word idx, then idx+1.
  - After writing DEPTH-1, moves to IDLE.
  - req_ready=0; requests are ignored.
- IDLE:
  - req_ready=1 every cycle, giving a throughput of 1 request per cycle.
  - A request is accepted when req_valid && req_ready.
- Word index = req_addr[IW+1:2]. Error when any of these holds:
  - req_addr[31:IW+2] ≠ 0 (no aliasing)
  - size 01 with addr[0]=1
  - size 10 with addr[1:0]≠0
  - size 11
- On error: no array write, rsp_err=1, rsp_rdata=0.
- Little-endian lane mapping:
  - Bytes use lane addr[1:0]; halfwords use bytes addr[1]*2 and addr[1]*2+1.
  - Stores modify only the addressed bytes; other bytes of the word are preserved (read-modify-write via byte enables).
- Loads extract the lane, then sign- or zero-extend to 32 bits per req_signed. Word loads ignore req_signed.
- There is no response backpressure; the consumer must take rsp_valid when it is presented.

## Timing
- Reset values (while reset=0): req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, init_done 0, peek_data 0, state INIT, idx 0.
- Init timing:
  - Edge k (k=1..DEPTH) after reset deassertion writes word k-1.
  - IDLE, req_ready=1 and init_done=1 from edge DEPTH onward.
- Request timing:
  - A request accepted at edge N gives rsp_valid=1 with rsp_rdata/rsp_err valid after edge N+1, for one cycle.
  - Stores commit to the array at edge N.
- Back-to-back store then load to the same word (edges N, N+1) returns the stored data.
- A load of the same word in the same cycle as a store is impossible: at most one request per cycle.
- peek_data = array[PEEK_IDX] sampled at each edge, so it lags writes by one cycle. It follows init writes.
- Reset asserted mid-operation: the in-flight response is dropped (rsp_valid→0 immediately) and init restarts from idx 0. Array contents are not relied upon until init_done.

## Configuration
- DMEM_PRELOAD_EN defined: init writes package table PRELOAD to words 0..PRELOAD_LEN-1 and 0 to all other words. The table is truncated if DEPTH < PRELOAD_LEN.
- DMEM_PRELOAD_EN undefined: init writes 0 to every word.
- Init duration is DEPTH cycles in both cases.

## Structure
- Package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state typedef
  - PRELOAD_LEN = 22
  - PRELOAD table: 5,5,2,12,1,12,3,20,2,15,1,8,4,1,8,1,4,2,6,5,5,1
- Sub-module dmem_lane_align (combinational): from addr[1:0], size, signed and wdata, produces byte enables, aligned write data, the extracted/extended load value and the misalign flag.

## Test plan
- Reset, wait: req_ready=0 for DEPTH cycles, then init_done=1; a word load of each of addresses 0x0..0x3FC returns 0. With DMEM_PRELOAD_EN: addr 0x1C → 20 and peek_data=1.
- Word store 0x12345678 to 0x40, then byte stores 0xAB to 0x41 and 0xCD to 0x43; word load 0x40 → 0xCD34AB78.
- From that state: load byte 0x41 signed → 0xFFFFFFAB; unsigned → 0x000000AB; half 0x42 signed → 0xFFFFCD34.
- Half load at 0x41, word store at 0x42, size 11, and addr 0x400 (DEPTH 256) → each rsp_err=1, rsp_rdata=0; word 0x40 is unchanged.
- Store 0x99 to word PEEK_IDX, then back-to-back loads of the same address: both return 0x99; peek_data=0x99 one cycle after the store edge.
- Assert reset during a streaming load: rsp_valid drops asynchronously; after release, init repeats for DEPTH cycles before req_ready=1.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory: access sizes, FSM states
// and the optional preload table.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_e;

  localparam int PRELOAD_LEN = 22;
  localparam logic [31:0] PRELOAD [PRELOAD_LEN] = '{
    32'd5, 32'd5, 32'd2, 32'd12, 32'd1, 32'd12, 32'd3, 32'd20, 32'd2, 32'd15, 32'd1,
    32'd8, 32'd4, 32'd1, 32'd8, 32'd1, 32'd4, 32'd2, 32'd6, 32'd5, 32'd5, 32'd1
  };

  // Words past the end of the table are cleared.
  function automatic logic [31:0] preload_word(input logic [31:0] i);
    if (i < 32'(PRELOAD_LEN)) return PRELOAD[i[4:0]];
    return '0;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response port of the data memory; master drives requests, slave
// is the memory.
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data for
// writes, lane extraction with sign/zero extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o       = '0;
    wdata_o    = '0;
    rdata_o    = '0;
    misalign_o = 1'b0;
    byte_sel   = rword_i[{addr_lo_i, 3'b000} +: 8];
    half_sel   = rword_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        misalign_o = addr_lo_i[0];
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{signed_i & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        misalign_o = |addr_lo_i;
        be_o       = 4'hF;
        wdata_o    = wdata_i;
        rdata_o    = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with post-reset init sequencer and two-stage
// response pipeline. Define DMEM_PRELOAD_EN to preload from dmem_pkg::PRELOAD.
//   state   | meaning
//   INIT    | writing init value to word idx, requests ignored
//   IDLE    | accepting one request per cycle
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int PEEK_IDX = 4
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_ctrl_if.slave     bus,
  output logic               init_done,
  output logic [31:0]        peek_data
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] PEEK_W = PEEK_IDX[IW-1:0];

  logic [31:0]   mem [DEPTH];
  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   init_word;

  logic          accept, req_err, st_misalign;
  logic [IW-1:0] req_idx;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  logic          s1_valid_q, s1_err_q, s1_load_q, s1_signed_q;
  logic [1:0]    s1_size_q, s1_lo_q;
  logic [31:0]   s1_word_q, ld_value;
  logic          rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_rdata_q, peek_q;

  logic [3:0]    ld_be;
  logic [31:0]   ld_wdata, st_rdata;
  logic          ld_misalign;
  logic          unused_lane;

`ifdef DMEM_PRELOAD_EN
  assign init_word = preload_word(32'(idx_q));
`else
  assign init_word = '0;
`endif

  assign req_idx = bus.req_addr[IW+1:2];
  assign req_err = (bus.req_addr[31:IW+2] != '0) || st_misalign || (bus.req_size == 2'b11);

  dmem_lane_align u_st_align (
    .addr_lo_i (bus.req_addr[1:0]),
    .size_i    (bus.req_size),
    .signed_i  (bus.req_signed),
    .wdata_i   (bus.req_wdata),
    .rword_i   ('0),
    .be_o      (st_be),
    .wdata_o   (st_wdata),
    .rdata_o   (st_rdata),
    .misalign_o(st_misalign)
  );

  // Load extraction runs a stage later, on the registered array read.
  dmem_lane_align u_ld_align (
    .addr_lo_i (s1_lo_q),
    .size_i    (s1_size_q),
    .signed_i  (s1_signed_q),
    .wdata_i   ('0),
    .rword_i   (s1_word_q),
    .be_o      (ld_be),
    .wdata_o   (ld_wdata),
    .rdata_o   (ld_value),
    .misalign_o(ld_misalign)
  );

  assign unused_lane = ^{ld_be, ld_wdata, ld_misalign, st_rdata};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wr_en         = 1'b0;
    wr_idx        = idx_q;
    wr_be         = 4'hF;
    wr_data       = init_word;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    case (state_q)
      ST_INIT: begin
        wr_en = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        accept        = bus.req_valid;
        if (accept && bus.req_wr && !req_err) begin
          wr_en   = 1'b1;
          wr_idx  = req_idx;
          wr_be   = st_be;
          wr_data = st_wdata;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Array kept free of reset so it maps onto block RAM with byte writes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    s1_word_q <= mem[req_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_load_q   <= 1'b0;
      s1_signed_q <= 1'b0;
      s1_size_q   <= '0;
      s1_lo_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      peek_q      <= '0;
    end else begin
      s1_valid_q  <= accept;
      s1_err_q    <= req_err;
      s1_load_q   <= !bus.req_wr;
      s1_signed_q <= bus.req_signed;
      s1_size_q   <= bus.req_size;
      s1_lo_q     <= bus.req_addr[1:0];
      rsp_valid_q <= s1_valid_q;
      rsp_err_q   <= s1_valid_q && s1_err_q;
      rsp_rdata_q <= (s1_valid_q && s1_load_q && !s1_err_q) ? ld_value : '0;
      peek_q      <= mem[PEEK_W];
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign init_done     = (state_q == ST_IDLE);
  assign peek_data     = peek_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, hand sequences for peek,
// back-to-back and mid-run reset, and randomized streaming against a model.
module tb_data_mem_ctrl;
  localparam int DEPTH    = 256;
  localparam int PEEK_IDX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init_done;
  logic [31:0] peek_data;

  data_mem_ctrl_if bus();

  data_mem_ctrl #(.DEPTH(DEPTH), .PEEK_IDX(PEEK_IDX)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .init_done(init_done),
    .peek_data(peek_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [DEPTH];
  int pre_tab [22] = '{5, 5, 2, 12, 1, 12, 3, 20, 2, 15, 1, 8, 4, 1, 8, 1, 4, 2, 6, 5, 5, 1};

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
`ifdef DMEM_PRELOAD_EN
    if (i < 22) return 32'(pre_tab[i]);
`endif
    return 32'd0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = init_val(i);
  endfunction

  function automatic void model_op(input logic wr, input logic [1:0] size, input logic sgn,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   output logic [31:0] rd, output logic err);
    int nbytes, idx, off;
    logic [31:0] mask, v;
    rd  = '0;
    err = 1'b0;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (size == 2'd3 || addr >= 32'(DEPTH * 4) || (addr % nbytes) != 0) begin
      err = 1'b1;
      return;
    end
    idx  = int'(addr / 4);
    off  = int'(addr % 4) * 8;
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    if (wr) begin
      model[idx] = (model[idx] & ~(mask << off)) | ((wdata & mask) << off);
    end else begin
      v = (model[idx] >> off) & mask;
      if (sgn && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
      rd = v;
    end
  endfunction

  task automatic drive(input logic vld, input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = vld;
    bus.req_wr     = wr;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  // Called at a negedge; returns the response sampled after edge N+1.
  task automatic single(input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic vld, output logic [31:0] rd, output logic err);
    drive(1'b1, wr, size, sgn, addr, wdata);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vld = bus.rsp_valid;
    rd  = bus.rsp_rdata;
    err = bus.rsp_err;
  endtask

  task automatic release_and_init(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    reset = 1'b1;
    do begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end while (bus.req_ready !== 1'b1 && k < 2 * DEPTH + 4);
    check({tag, " init edges"}, 32'(k), 32'(DEPTH));
    check({tag, " init_done"}, 32'(init_done), 32'd1);
    model_reset();
  endtask

  vec_t vecs [16];
  exp_t p1, p2, nw;
  logic        vld, err, merr;
  logic [31:0] rd, mrd, old_peek, a, wd;
  logic [1:0]  sz;
  logic        wr, sg;

  initial begin
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h40,  32'h1234_5678, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h41,  32'h0000_00AB, 32'h0,         1'b0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h43,  32'h0000_00CD, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h40,  32'h0,         32'hCD34_AB78, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h41,  32'h0,         32'hFFFF_FFAB, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h41,  32'h0,         32'h0000_00AB, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h42,  32'h0,         32'hFFFF_CD34, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h41,  32'h0,         32'h0,         1'b1};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h42,  32'hDEAD_BEEF, 32'h0,         1'b1};
    vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h40,  32'h0,         32'h0,         1'b1};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,         32'h0,         1'b1};
    vecs[11] = '{1'b0, 2'd2, 1'b1, 32'h40,  32'h0,         32'hCD34_AB78, 1'b0};
    vecs[12] = '{1'b0, 2'd1, 1'b0, 32'h40,  32'h0,         32'h0000_AB78, 1'b0};
    vecs[13] = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h1111_BEEF, 32'h0,         1'b0};
    vecs[14] = '{1'b1, 2'd0, 1'b0, 32'h101, 32'hFFFF_FF12, 32'h0,         1'b0};
    vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,         32'hBEEF_1200, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", 32'(bus.req_ready), 32'd0);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst init_done", 32'(init_done), 32'd0);
    check("rst peek_data", peek_data, 32'd0);
    release_and_init("first");

    // Sweep every word after init
    for (int w = 0; w < DEPTH; w++) begin
      single(1'b0, 2'd2, 1'b0, 32'(w * 4), 32'd0, vld, rd, err);
      check("sweep valid", 32'(vld), 32'd1);
      check("sweep rdata", rd, init_val(w));
    end
    check("init peek", peek_data, init_val(PEEK_IDX));

    // Directed vectors
    for (int i = 0; i < 16; i++) begin
      single(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, vld, rd, err);
      model_op(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, mrd, merr);
      check($sformatf("vec%0d valid", i), 32'(vld), 32'd1);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
    end

    // Store to peek word then back-to-back loads of it
    old_peek = model[PEEK_IDX];
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'(PEEK_IDX * 4), 32'h99);
    model_op(1'b1, 2'd2, 1'b0, 32'(PEEK_IDX * 4), 32'h99, mrd, merr);
    @(posedge clk);
    @(negedge clk);
    check("peek before lag", peek_data, old_peek);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'(PEEK_IDX * 4), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("peek after store", peek_data, 32'h99);
    check("b2b store valid", 32'(bus.rsp_valid), 32'd1);
    check("b2b store rdata", bus.rsp_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("b2b load1 valid", 32'(bus.rsp_valid), 32'd1);
    check("b2b load1 rdata", bus.rsp_rdata, 32'h99);
    @(posedge clk);
    @(negedge clk);
    check("b2b load2 valid", 32'(bus.rsp_valid), 32'd1);
    check("b2b load2 rdata", bus.rsp_rdata, 32'h99);
    @(posedge clk);
    @(negedge clk);
    check("b2b idle valid", 32'(bus.rsp_valid), 32'd0);

    // Randomized streaming against the model
    p1 = '{1'b0, 32'd0, 1'b0};
    p2 = '{1'b0, 32'd0, 1'b0};
    for (int c = 0; c < 600; c++) begin
      check("rnd valid", 32'(bus.rsp_valid), 32'(p2.v));
      if (p2.v) begin
        check("rnd rdata", bus.rsp_rdata, p2.rd);
        check("rnd err", 32'(bus.rsp_err), 32'(p2.err));
      end
      p2 = p1;
      nw = '{1'b0, 32'd0, 1'b0};
      if (c < 596 && $urandom_range(0, 3) != 0) begin
        nw.v = 1'b1;
        wr = 1'($urandom_range(0, 1));
        sg = 1'($urandom_range(0, 1));
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'h80 + 32'($urandom_range(0, 31));
        wd = $urandom;
        model_op(wr, sz, sg, a, wd, nw.rd, nw.err);
        drive(1'b1, wr, sz, sg, a, wd);
      end else begin
        bus.req_valid = 1'b0;
      end
      p1 = nw;
      @(posedge clk);
      @(negedge clk);
    end

    // Reset in the middle of a load stream
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre-reset valid", 32'(bus.rsp_valid), 32'd1);
    check("pre-reset rdata", bus.rsp_rdata, model[32]);
    #2;
    reset = 1'b0;
    #1;
    check("async drop valid", 32'(bus.rsp_valid), 32'd0);
    check("async drop ready", 32'(bus.req_ready), 32'd0);
    check("async init_done", 32'(init_done), 32'd0);
    bus.req_valid = 1'b0;
    release_and_init("second");
    single(1'b0, 2'd2, 1'b0, 32'h80, 32'd0, vld, rd, err);
    check("reinit valid", 32'(vld), 32'd1);
    check("reinit rdata", rd, init_val(32));
    single(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, vld, rd, err);
    check("reinit word 0x40", rd, init_val(16));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
